// File: rtl/io_input_responder_pkg.sv
// Shared types and default sizes for the input-instruction responder.
package io_input_responder_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StArm       = 2'd1,
        StWaitPress = 2'd2,
        StDone      = 2'd3
    } state_e;

    localparam int unsigned DefInW      = 18;
    localparam int unsigned DefDataW    = 32;
    localparam int unsigned DefDbCycles = 50000;

endpackage

// File: rtl/io_debouncer.sv
// Push-button synchronizer and debouncer with a press (rising stable level) event.
module io_debouncer #(
    parameter int unsigned DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_btn_n,
    output logic btn_stable,
    output logic press_evt
);

    localparam int unsigned CntW = $clog2(DB_CYCLES + 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic            stable_prev_q;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= ~raw_btn_n;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    // The toggle happens on the edge where the count would reach DB_CYCLES.
    always_comb begin
        cnt_inc  = cnt_q + CntW'(1);
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_inc == CntW'(DB_CYCLES)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    assign btn_stable = stable_q;
    assign press_evt  = stable_q & ~stable_prev_q;

endmodule

// File: rtl/io_input_responder.sv
// Stalls the core on an input request until a debounced button press, then
// returns the synchronized switch word with a one-cycle valid strobe.
module io_input_responder
    import io_input_responder_pkg::*;
#(
    parameter int unsigned IN_W      = DefInW,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned DB_CYCLES = DefDbCycles,
    parameter int unsigned SIGN_EXT  = 0
) (
    input  logic              Sys_Clock,
    input  logic              Reset,
    input  logic              In_Req,
    input  logic              Raw_Button_N,
    input  logic [IN_W-1:0]   Raw_Input,
    output logic              Stall,
    output logic [DATA_W-1:0] Data_In,
    output logic              Data_Valid,
    output logic              Busy
);

    state_e              state_q, state_d;
    logic [IN_W-1:0]     sw_sync1_q, sw_sync2_q;
    logic [DATA_W-1:0]   data_q, data_ext;
    logic                valid_q;
    logic                btn_stable, press_evt;
    logic                capture;

    io_debouncer #(
        .DB_CYCLES(DB_CYCLES)
    ) u_debouncer (
        .clk       (Sys_Clock),
        .rst_n     (Reset),
        .raw_btn_n (Raw_Button_N),
        .btn_stable(btn_stable),
        .press_evt (press_evt)
    );

    assign data_ext = (SIGN_EXT != 0) ? {{(DATA_W-IN_W){sw_sync2_q[IN_W-1]}}, sw_sync2_q}
                                      : {{(DATA_W-IN_W){1'b0}}, sw_sync2_q};

    // An abort (In_Req low) wins over a simultaneous press.
    assign capture = (state_q == StWaitPress) && In_Req && press_evt;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (In_Req) state_d = StArm;
            StArm: begin
                if (!In_Req)          state_d = StIdle;
                else if (!btn_stable) state_d = StWaitPress;
            end
            StWaitPress: begin
                if (!In_Req)       state_d = StIdle;
                else if (press_evt) state_d = StDone;
            end
            StDone:      if (!In_Req) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge Sys_Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sw_sync1_q <= Raw_Input;
            sw_sync2_q <= sw_sync1_q;
            valid_q    <= capture;
            if (capture) begin
                data_q <= data_ext;
            end
        end
    end

    // Gated by Reset so the core is never stalled while the block is held in reset.
    assign Stall      = Reset & In_Req & (state_q != StDone);
    assign Data_In    = data_q;
    assign Data_Valid = valid_q;
    assign Busy       = (state_q != StIdle);

endmodule

// File: tb/tb_io_input_responder.sv
// Directed bench for io_input_responder with DB_CYCLES=4, zero- and sign-extending instances.
module tb_io_input_responder;

    localparam int unsigned IN_W   = 18;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DB     = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_req;
    logic              btn_n;
    logic [IN_W-1:0]   raw;
    logic              stall, valid, busy;
    logic              stall_sx, valid_sx, busy_sx;
    logic [DATA_W-1:0] data, data_sx;

    int nchecks = 0;
    int nerrors = 0;
    int vcount  = 0;

    always #5 clk = ~clk;

    io_input_responder #(
        .IN_W(IN_W), .DATA_W(DATA_W), .DB_CYCLES(DB), .SIGN_EXT(0)
    ) dut (
        .Sys_Clock   (clk),
        .Reset       (rst_n),
        .In_Req      (in_req),
        .Raw_Button_N(btn_n),
        .Raw_Input   (raw),
        .Stall       (stall),
        .Data_In     (data),
        .Data_Valid  (valid),
        .Busy        (busy)
    );

    io_input_responder #(
        .IN_W(IN_W), .DATA_W(DATA_W), .DB_CYCLES(DB), .SIGN_EXT(1)
    ) dut_sx (
        .Sys_Clock   (clk),
        .Reset       (rst_n),
        .In_Req      (in_req),
        .Raw_Button_N(btn_n),
        .Raw_Input   (raw),
        .Stall       (stall_sx),
        .Data_In     (data_sx),
        .Data_Valid  (valid_sx),
        .Busy        (busy_sx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        if (obs !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n clocks; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            vcount += int'(valid);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        in_req = 1'b0;
        btn_n  = 1'b1;
        raw    = '0;
        #12;
        in_req = 1'b1;
        #1;
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_data", data, 32'd0);
        in_req = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);

        // Basic capture
        raw    = 18'h00ABC;
        in_req = 1'b1;
        #1;
        check("basic_stall_rise", {31'd0, stall}, 32'd1);
        step(2);
        check("basic_busy", {31'd0, busy}, 32'd1);
        btn_n  = 1'b0;
        vcount = 0;
        step(6);
        check("basic_no_early_valid", vcount, 0);
        step(1);
        check("basic_valid", {31'd0, valid}, 32'd1);
        check("basic_data", data, 32'h00000ABC);
        check("basic_data_sx", data_sx, 32'h00000ABC);
        check("basic_stall_fall", {31'd0, stall}, 32'd0);
        step(1);
        check("basic_valid_one_cycle", {31'd0, valid}, 32'd0);
        step(2);
        btn_n  = 1'b1;
        vcount = 0;
        step(8);
        check("done_release_no_valid", vcount, 0);
        check("done_release_data", data, 32'h00000ABC);
        check("done_release_stall", {31'd0, stall}, 32'd0);
        in_req = 1'b0;
        step(1);
        check("drop_busy", {31'd0, busy}, 32'd0);

        // Debounce: short low pulses must never register
        in_req = 1'b1;
        step(2);
        vcount = 0;
        for (int w = 1; w <= 3; w++) begin
            btn_n = 1'b0;
            step(w);
            btn_n = 1'b1;
            step(8);
        end
        check("bounce_no_valid", vcount, 0);
        check("bounce_stall", {31'd0, stall}, 32'd1);
        check("bounce_data", data, 32'h00000ABC);

        // Sign extension (state still WAIT_PRESS)
        raw   = 18'h20001;
        btn_n = 1'b0;
        step(7);
        check("ext_valid", {31'd0, valid}, 32'd1);
        check("ext_zero", data, 32'h00020001);
        check("ext_sign", data_sx, 32'hFFFE0001);
        in_req = 1'b0;
        step(1);

        // Held button: ARM must wait for a release
        in_req = 1'b1;
        vcount = 0;
        step(10);
        check("held_no_valid", vcount, 0);
        check("held_busy", {31'd0, busy}, 32'd1);
        check("held_stall", {31'd0, stall}, 32'd1);
        btn_n = 1'b1;
        raw   = 18'h00123;
        step(8);
        btn_n  = 1'b0;
        vcount = 0;
        step(6);
        check("held_no_early_valid", vcount, 0);
        step(1);
        check("held_valid", {31'd0, valid}, 32'd1);
        check("held_data", data, 32'h00000123);

        // No second capture while In_Req stays high
        raw   = 18'h00777;
        btn_n = 1'b1;
        step(8);
        btn_n  = 1'b0;
        vcount = 0;
        step(10);
        check("nogap_no_valid", vcount, 0);
        check("nogap_data", data, 32'h00000123);
        check("nogap_stall", {31'd0, stall}, 32'd0);

        // Abort coincident with the press event
        in_req = 1'b0;
        step(1);
        check("abort_pre_busy", {31'd0, busy}, 32'd0);
        in_req = 1'b1;
        raw    = 18'h00555;
        step(1);
        btn_n = 1'b1;
        step(8);
        check("abort_wait_busy", {31'd0, busy}, 32'd1);
        btn_n  = 1'b0;
        vcount = 0;
        step(6);
        in_req = 1'b0;
        step(1);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_data", data, 32'h00000123);
        check("abort_busy", {31'd0, busy}, 32'd0);
        step(2);
        check("abort_no_late_valid", vcount, 0);

        // Async reset in the middle of DONE
        in_req = 1'b1;
        step(1);
        btn_n = 1'b1;
        step(8);
        btn_n = 1'b0;
        step(7);
        check("pre_reset_valid", {31'd0, valid}, 32'd1);
        check("pre_reset_data", data, 32'h00000555);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_stall", {31'd0, stall}, 32'd0);
        check("areset_valid", {31'd0, valid}, 32'd0);
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_data", data, 32'd0);
        btn_n = 1'b1;
        step(3);
        rst_n  = 1'b1;
        vcount = 0;
        step(12);
        check("post_reset_no_valid", vcount, 0);
        check("post_reset_busy", {31'd0, busy}, 32'd1);
        check("post_reset_data", data, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
